// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control slice: opcodes, FSM states, default width.
package alu_pkg;

    localparam int DATA_W_DEF = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_LDI = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

endpackage

// File: rtl/alu_regfile.sv
// Register file: one synchronous write port, three combinational read ports,
// synchronous active-low clear that takes priority over a write.
module alu_regfile #(
    parameter int DATA_W = 4,
    parameter int NREGS  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rs1_addr,
    output logic [DATA_W-1:0] rs1_data,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs2_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] mem_q [NREGS];
    logic [DATA_W-1:0] mem_d [NREGS];

    // Next-state of the storage array: copy, then overlay the write
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end else begin
            mem_d[wr_addr] = mem_q[wr_addr];
        end
    end

    // Storage flops with synchronous clear
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (!rst_n) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end else begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rs1_data = mem_q[rs1_addr];
    assign rs2_data = mem_q[rs2_addr];
    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_regfile_ctrl.sv
// Control stage for the external 4-bit ALU: accepts commands over valid/ready,
// drives registered ALU operands, and writes the ALU result back into the register file.
module alu_regfile_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREGS  = 4,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              done,
    output logic              zero_flag,
    output logic [CNT_W-1:0]  ops_cnt,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic              alu_sel_q, alu_sel_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic              done_q, done_d;
    logic              zero_flag_q, zero_flag_d;
    logic [CNT_W-1:0]  ops_cnt_q, ops_cnt_d;

    logic              accept_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;
    logic [DATA_W-1:0] rs1_data_s;
    logic [DATA_W-1:0] rs2_data_s;

    alu_regfile #(
        .DATA_W(DATA_W),
        .NREGS (NREGS),
        .ADDR_W(ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en_s),
        .wr_addr (wr_addr_s),
        .wr_data (wr_data_s),
        .rs1_addr(cmd_rs1),
        .rs1_data(rs1_data_s),
        .rs2_addr(cmd_rs2),
        .rs2_data(rs2_data_s),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    assign cmd_ready = rst_n && (state_q == ST_IDLE);
    assign accept_s  = cmd_valid && cmd_ready;

    // Next-state, register-file write port and counters
    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rd_d        = rd_q;
        done_d      = 1'b0;
        zero_flag_d = zero_flag_q;
        ops_cnt_d   = ops_cnt_q;
        wr_en_s     = 1'b0;
        wr_addr_s   = rd_q;
        wr_data_s   = alu_result;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    case (cmd_op)
                        OP_ADD, OP_AND: begin
                            // Operands captured now, so writeback never races a later read
                            alu_a_d   = rs1_data_s;
                            alu_b_d   = rs2_data_s;
                            alu_sel_d = cmd_op[0];
                            rd_d      = cmd_rd;
                            state_d   = ST_EXEC;
                        end
                        OP_LDI: begin
                            wr_en_s     = 1'b1;
                            wr_addr_s   = cmd_rd;
                            wr_data_s   = cmd_imm;
                            zero_flag_d = (cmd_imm == {DATA_W{1'b0}});
                            done_d      = 1'b1;
                            ops_cnt_d   = ops_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                        OP_NOP: begin
                            done_d    = 1'b1;
                            ops_cnt_d = ops_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                wr_en_s     = 1'b1;
                wr_addr_s   = rd_q;
                wr_data_s   = alu_result;
                zero_flag_d = alu_zero;
                done_d      = 1'b1;
                ops_cnt_d   = ops_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control flops with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            alu_a_q     <= {DATA_W{1'b0}};
            alu_b_q     <= {DATA_W{1'b0}};
            alu_sel_q   <= 1'b0;
            rd_q        <= {ADDR_W{1'b0}};
            done_q      <= 1'b0;
            zero_flag_q <= 1'b0;
            ops_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rd_q        <= rd_d;
            done_q      <= done_d;
            zero_flag_q <= zero_flag_d;
            ops_cnt_q   <= ops_cnt_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign done      = done_q;
    assign zero_flag = zero_flag_q;
    assign ops_cnt   = ops_cnt_q;

endmodule

// File: tb/tb_alu_regfile_ctrl.sv
// Self-checking bench for alu_regfile_ctrl with a behavioural 4-bit ALU attached.
module tb_alu_regfile_ctrl;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_rd, cmd_rs1, cmd_rs2;
    logic [3:0] cmd_imm;
    logic [3:0] alu_a, alu_b, alu_result;
    logic       alu_sel, alu_zero;
    logic       done, zero_flag;
    logic [7:0] ops_cnt;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;
    logic [4:0] alu_sum;

    always #5 clk = ~clk;

    assign alu_sum    = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_result = alu_sel ? (alu_a & alu_b) : alu_sum[3:0];
    assign alu_zero   = (alu_result == 4'h0);

    alu_regfile_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_imm(cmd_imm), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_zero(alu_zero), .done(done),
        .zero_flag(zero_flag), .ops_cnt(ops_cnt), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    typedef struct {
        logic [1:0] op;
        logic [1:0] rd, rs1, rs2;
        logic [3:0] imm;
        logic [3:0] exp_val;
        logic       exp_zero;
    } vec_t;

    typedef struct {
        logic [1:0] rd;
        logic [3:0] val;
        logic       zero;
        int         lat;
        logic [7:0] cnt;
    } exp_t;

    vec_t       vecs [15];
    exp_t       sb [$];
    int         n_vec  = 0;
    int         n_fail = 0;
    logic [7:0] exp_cnt = 8'd0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_cmd(input vec_t v);
        int   waited;
        int   lat;
        exp_t e;
        exp_t got;
        @(negedge clk);
        cmd_op = v.op; cmd_rd = v.rd; cmd_rs1 = v.rs1; cmd_rs2 = v.rs2; cmd_imm = v.imm;
        cmd_valid = 1'b1;
        waited = 0;
        while (!cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("accept_wait", int'(waited < 20), 1);
        @(posedge clk);
        exp_cnt = exp_cnt + 8'd1;
        e.rd = v.rd; e.val = v.exp_val; e.zero = v.exp_zero; e.cnt = exp_cnt;
        e.lat = (v.op == OP_ADD || v.op == OP_AND) ? 2 : 1;
        sb.push_back(e);
        lat = 0;
        do begin
            @(negedge clk);
            cmd_valid = 1'b0;
            lat++;
        end while (!done && lat < 10);
        check("done_seen", int'(done), 1);
        got = sb.pop_front();
        check("latency", lat, got.lat);
        check("zero_flag", int'(zero_flag), int'(got.zero));
        check("ops_cnt", int'(ops_cnt), int'(got.cnt));
        dbg_addr = got.rd;
        #1;
        check("reg_value", int'(dbg_data), int'(got.val));
        @(negedge clk);
        check("done_width", int'(done), 0);
    endtask

    task automatic set_vec(input int i, input logic [1:0] op, input logic [1:0] rd,
                           input logic [1:0] rs1, input logic [1:0] rs2,
                           input logic [3:0] imm, input logic [3:0] ev, input logic ez);
        vecs[i].op = op; vecs[i].rd = rd; vecs[i].rs1 = rs1; vecs[i].rs2 = rs2;
        vecs[i].imm = imm; vecs[i].exp_val = ev; vecs[i].exp_zero = ez;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        //      idx op      rd     rs1    rs2    imm   exp   zero
        set_vec(0,  OP_LDI, 2'd0, 2'd0, 2'd0, 4'h9, 4'h9, 1'b0);
        set_vec(1,  OP_LDI, 2'd1, 2'd0, 2'd0, 4'h8, 4'h8, 1'b0);
        set_vec(2,  OP_ADD, 2'd2, 2'd0, 2'd1, 4'h0, 4'h1, 1'b0);
        set_vec(3,  OP_LDI, 2'd0, 2'd0, 2'd0, 4'hA, 4'hA, 1'b0);
        set_vec(4,  OP_LDI, 2'd1, 2'd0, 2'd0, 4'h5, 4'h5, 1'b0);
        set_vec(5,  OP_AND, 2'd3, 2'd0, 2'd1, 4'h0, 4'h0, 1'b1);
        set_vec(6,  OP_LDI, 2'd1, 2'd0, 2'd0, 4'h3, 4'h3, 1'b0);
        set_vec(7,  OP_ADD, 2'd1, 2'd1, 2'd1, 4'h0, 4'h6, 1'b0);
        set_vec(8,  OP_AND, 2'd0, 2'd1, 2'd1, 4'h0, 4'h6, 1'b0);
        set_vec(9,  OP_LDI, 2'd2, 2'd0, 2'd0, 4'h0, 4'h0, 1'b1);
        set_vec(10, OP_NOP, 2'd1, 2'd0, 2'd0, 4'hF, 4'h6, 1'b1);
        set_vec(11, OP_ADD, 2'd3, 2'd0, 2'd2, 4'h0, 4'h6, 1'b0);
        set_vec(12, OP_LDI, 2'd3, 2'd0, 2'd0, 4'hA, 4'hA, 1'b0);
        set_vec(13, OP_ADD, 2'd2, 2'd3, 2'd1, 4'h0, 4'h0, 1'b1);
        set_vec(14, OP_NOP, 2'd3, 2'd0, 2'd0, 4'h0, 4'hA, 1'b1);

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP;
        cmd_rd = 2'd0; cmd_rs1 = 2'd0; cmd_rs2 = 2'd0; cmd_imm = 4'h0; dbg_addr = 2'd0;
        repeat (3) @(negedge clk);
        check("ready_in_reset", int'(cmd_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_ready", int'(cmd_ready), 1);
        check("reset_zero", int'(zero_flag), 0);
        check("reset_cnt", int'(ops_cnt), 0);
        check("reset_done", int'(done), 0);
        check("reset_alu_a", int'(alu_a), 0);
        check("reset_alu_b", int'(alu_b), 0);
        check("reset_alu_sel", int'(alu_sel), 0);
        for (int r = 0; r < 4; r++) begin
            dbg_addr = r[1:0];
            #1;
            check("reset_reg", int'(dbg_data), 0);
        end

        for (int i = 0; i < 15; i++) begin
            run_cmd(vecs[i]);
        end

        // cmd_valid held through EXEC: r2 = r0 + r1 = 6 + 6, then LDI r3 = 0
        @(negedge clk);
        cmd_op = OP_ADD; cmd_rd = 2'd2; cmd_rs1 = 2'd0; cmd_rs2 = 2'd1; cmd_valid = 1'b1;
        check("hold_ready_idle", int'(cmd_ready), 1);
        @(posedge clk);
        @(negedge clk);
        check("hold_ready_exec", int'(cmd_ready), 0);
        check("hold_alu_a", int'(alu_a), 6);
        check("hold_alu_sel", int'(alu_sel), 0);
        check("hold_done_early", int'(done), 0);
        cmd_op = OP_LDI; cmd_rd = 2'd3; cmd_imm = 4'h0;
        @(posedge clk);
        @(negedge clk);
        check("hold_add_done", int'(done), 1);
        check("hold_ready_back", int'(cmd_ready), 1);
        dbg_addr = 2'd2;
        #1;
        check("hold_add_val", int'(dbg_data), 12);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("hold_ldi_done", int'(done), 1);
        check("hold_ldi_zero", int'(zero_flag), 1);
        dbg_addr = 2'd3;
        #1;
        check("hold_ldi_val", int'(dbg_data), 0);
        exp_cnt = exp_cnt + 8'd2;
        check("hold_cnt", int'(ops_cnt), int'(exp_cnt));

        // 256 back-to-back NOPs: done every cycle, counter returns to its start
        @(negedge clk);
        cmd_op = OP_NOP; cmd_valid = 1'b1;
        bad = 0;
        repeat (256) begin
            @(posedge clk);
            @(negedge clk);
            if (!done) bad++;
        end
        cmd_valid = 1'b0;
        check("nop_train_done", bad, 0);
        check("nop_wrap_cnt", int'(ops_cnt), int'(exp_cnt));
        dbg_addr = 2'd2;
        #1;
        check("nop_reg_kept", int'(dbg_data), 12);

        // Reset during EXEC of r2 = 7 + 1
        begin
            vec_t v;
            v.op = OP_LDI; v.rd = 2'd0; v.rs1 = 2'd0; v.rs2 = 2'd0; v.imm = 4'h7;
            v.exp_val = 4'h7; v.exp_zero = 1'b0;
            run_cmd(v);
            v.rd = 2'd1; v.imm = 4'h1; v.exp_val = 4'h1;
            run_cmd(v);
        end
        @(negedge clk);
        cmd_op = OP_ADD; cmd_rd = 2'd2; cmd_rs1 = 2'd0; cmd_rs2 = 2'd1; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rst_exec_state", int'(cmd_ready), 0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_exec_done", int'(done), 0);
        check("rst_exec_ready", int'(cmd_ready), 0);
        rst_n = 1'b1;
        exp_cnt = 8'd0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) bad++;
        end
        check("rst_no_done", bad, 0);
        check("rst_ready", int'(cmd_ready), 1);
        check("rst_cnt", int'(ops_cnt), int'(exp_cnt));
        check("rst_zero", int'(zero_flag), 0);
        dbg_addr = 2'd2;
        #1;
        check("rst_r2", int'(dbg_data), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_regfile_ctrl.md
Name: alu_regfile_ctrl

Overview:
- Upstream control stage for the 4-bit ALU (operands A/B, selector sel: 0 = add, 1 = AND; outputs result and zero flag).
- Holds a small register file and accepts commands over a valid/ready handshake.
- For each command it drives the ALU operands and selector, then writes the ALU result and zero flag back.
- Also supports load-immediate, so a bench or upstream sequencer can seed register values.

Parameters:
- DATA_W, 4, operand/register width; must match the ALU width.
- NREGS, 4, number of registers in the file.
- ADDR_W, 2, register index width; must equal clog2(NREGS).
- CNT_W, 8, width of the completed-command counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  00 ADD, 01 AND, 10 LDI, 11 NOP.
- cmd_rd  in  ADDR_W  destination register.
- cmd_rs1  in  ADDR_W  source register for operand A.
- cmd_rs2  in  ADDR_W  source register for operand B.
- cmd_imm  in  DATA_W  immediate value for LDI.
- alu_a  out  DATA_W  to ALU A; registered.
- alu_b  out  DATA_W  to ALU B; registered.
- alu_sel  out  1  to ALU sel; registered.
- alu_result  in  DATA_W  from ALU result.
- alu_zero  in  1  from ALU zero flag.
- done  out  1  one-cycle pulse per completed command.
- zero_flag  out  1  zero status of the last write.
- ops_cnt  out  CNT_W  number of completed commands; wraps.
- dbg_addr  in  ADDR_W  debug read index.
- dbg_data  out  DATA_W  combinational read of reg[dbg_addr].

Behaviour:
- Clocking and reset:
  - One clock, clk; reset rst_n is synchronous and active-low.
  - While rst_n=0 at a rising edge, the next state is: all registers 0, state IDLE, alu_a=0, alu_b=0, alu_sel=0, done=0, zero_flag=0, ops_cnt=0.
  - cmd_ready is forced to 0 while rst_n=0.
- FSM has two states, IDLE and EXEC.
  - cmd_ready = rst_n && (state==IDLE).
  - Accept occurs on a rising edge where cmd_valid && cmd_ready.
- IDLE accept with ADD or AND:
  - alu_a <= reg[rs1], alu_b <= reg[rs2], alu_sel <= cmd_op[0].
  - Latch rd; state -> EXEC.
- EXEC, one cycle:
  - The ALU settles combinationally.
  - At the end edge: reg[rd] <= alu_result, zero_flag <= alu_zero, done <= 1, ops_cnt += 1, state -> IDLE.
- IDLE accept with LDI:
  - reg[rd] <= cmd_imm, zero_flag <= (cmd_imm==0), done <= 1, ops_cnt += 1.
  - State stays IDLE; alu_* outputs are unchanged.
- IDLE accept with NOP: done <= 1, ops_cnt += 1; no register or flag change.
- Latency and throughput:
  - ADD/AND: done is high in the 2nd cycle after the accept edge; throughput is 1 command per 2 cycles.
  - LDI/NOP: done is high in the cycle after the accept edge; back-to-back accepts are allowed.
- done is high for exactly one cycle per command; otherwise it is 0.
- Hazards:
  - Operands are latched at accept, and writeback completes before the next accept can occur.
  - Therefore rd==rs1, rd==rs2, rs1==rs2, and read-after-write on consecutive commands all need no stall.
- cmd_* inputs are ignored when not accepted. cmd_valid held high during EXEC is not consumed until IDLE.
- ALU arithmetic is modulo 2^DATA_W (carry dropped); this block does not recompute the flag and uses alu_zero.
- ops_cnt wraps from 2^CNT_W-1 to 0.
- Reset during EXEC: the pending writeback is discarded, and the reset values above apply at that edge.
- dbg_data reflects a write starting the cycle after the write edge.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants OP_ADD=2'b00, OP_AND=2'b01, OP_LDI=2'b10, OP_NOP=2'b11.
  - State encoding ST_IDLE/ST_EXEC.
  - Default DATA_W.
- One natural sub-module: alu_regfile.
  - NREGS x DATA_W, one synchronous write port, three combinational read ports (rs1, rs2, dbg), synchronous active-low clear.
- The FSM and handshake stay in the top module. Bench instantiates the existing ALU alongside.

Test Plan:
- Reset, then read all dbg addresses -> each returns 0; zero_flag=0, ops_cnt=0, cmd_ready=1 one cycle after rst_n rises.
- LDI r0=4'h9, LDI r1=4'h8, ADD r2=r0+r1 -> r2=4'h1 (carry dropped), zero_flag=0, done at accept+2, ops_cnt=3.
- LDI r0=4'hA, LDI r1=4'h5, AND r3=r0&r1 -> r3=4'h0, zero_flag=1; cmd_ready=0 during EXEC with cmd_valid held, next command accepted at the following edge.
- ADD r1=r1+r1 with r1=4'h3, then AND r0=r1&r1 back-to-back -> r1=4'h6, r0=4'h6; no stale operand.
- LDI r2=0 -> zero_flag=1 with done the next cycle; NOP -> registers unchanged, done pulses, ops_cnt increments; 256 NOPs -> ops_cnt wraps to its start value.
- rst_n low during EXEC of ADD r2=4'h7+4'h1 -> r2 stays 0, done never pulses, state IDLE after reset.
